// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the unified memory arbiter
package mem_arb_pkg;

    localparam int AW_DEF       = 10;
    localparam int DW_DEF       = 32;
    localparam int MAX_WAIT_DEF = 4;

    // Bit positions inside the one-hot winner vector
    localparam int WIN_IF = 0;
    localparam int WIN_DM = 1;
    localparam int WIN_LD = 2;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM,
        OWN_LD
    } owner_e;

    typedef enum logic {
        ARB,
        LOCKED
    } state_e;

endpackage

// File: rtl/imem_dmem_arbiter_prio_sel.sv
// rtl/imem_dmem_arbiter_prio_sel.sv - combinational priority select with fetch anti-starvation
// Ports:
//   if_req, dm_req, ld_req : requests from fetch, data and loader ports
//   locked                 : loader owns the memory, only ld may win
//   starve                 : fetch has waited the maximum number of cycles
//   winner                 : one-hot winner, bit order from mem_arb_pkg WIN_*
module arb_prio_sel
    import mem_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       dm_req,
    input  logic       ld_req,
    input  logic       locked,
    input  logic       starve,
    output logic [2:0] winner
);

    always_comb begin
        winner = '0;
        if (ld_req) begin
            winner[WIN_LD] = 1'b1;
        end else if (!locked) begin
            // A starved fetch jumps ahead of the data port
            if (if_req && starve) begin
                winner[WIN_IF] = 1'b1;
            end else if (dm_req) begin
                winner[WIN_DM] = 1'b1;
            end else if (if_req) begin
                winner[WIN_IF] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - single-port memory arbiter for fetch, data and loader ports
// Ports:
//   clk1, rst_n                          : clock, async active-low reset
//   if_*  : fetch read port   (req/addr in, gnt/rvalid/rdata out)
//   dm_*  : data port         (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   ld_*  : loader port       (req/lock/we/addr/wdata in, gnt/rvalid/rdata out)
//   mem_* : memory side, read data arrives the cycle after a read
//   locked: loader currently owns the memory
module imem_dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    input  logic          ld_req,
    input  logic          ld_lock,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          locked
);

    state_e        state;
    owner_e        tag;
    owner_e        win_owner;
    logic [3:0]    wait_cnt;
    logic [2:0]    winner;
    logic          starve;
    logic [DW-1:0] if_hold;
    logic [DW-1:0] dm_hold;
    logic [DW-1:0] ld_hold;

    assign locked = (state == LOCKED);
    assign starve = (wait_cnt == 4'(MAX_WAIT));

    arb_prio_sel u_sel (
        .if_req (if_req),
        .dm_req (dm_req),
        .ld_req (ld_req),
        .locked (locked),
        .starve (starve),
        .winner (winner)
    );

    assign if_gnt = winner[WIN_IF];
    assign dm_gnt = winner[WIN_DM];
    assign ld_gnt = winner[WIN_LD];
    assign mem_en = |winner;

    // Memory-side mux; everything stays low when nobody wins
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        win_owner = OWN_NONE;
        if (winner[WIN_LD]) begin
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            win_owner = OWN_LD;
        end else if (winner[WIN_DM]) begin
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            win_owner = OWN_DM;
        end else if (winner[WIN_IF]) begin
            mem_addr  = if_addr;
            win_owner = OWN_IF;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB;
            wait_cnt <= 4'd0;
            tag      <= OWN_NONE;
            if_hold  <= '0;
            dm_hold  <= '0;
            ld_hold  <= '0;
        end else begin
            case (state)
                ARB:     if (ld_gnt && ld_lock) state <= LOCKED;
                LOCKED:  if (!ld_lock) state <= ARB;
                default: state <= ARB;
            endcase

            if (!if_req || if_gnt) begin
                wait_cnt <= 4'd0;
            end else if (!starve) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            // Tag follows the read issued this cycle; writes leave no tag
            tag <= (mem_en && !mem_we) ? win_owner : OWN_NONE;

            // Returned data is kept so rdata holds between reads
            case (tag)
                OWN_IF:  if_hold <= mem_rdata;
                OWN_DM:  dm_hold <= mem_rdata;
                OWN_LD:  ld_hold <= mem_rdata;
                default: ;
            endcase
        end
    end

    assign if_rvalid = (tag == OWN_IF);
    assign dm_rvalid = (tag == OWN_DM);
    assign ld_rvalid = (tag == OWN_LD);

    assign if_rdata = if_rvalid ? mem_rdata : if_hold;
    assign dm_rdata = dm_rvalid ? mem_rdata : dm_hold;
    assign ld_rdata = ld_rvalid ? mem_rdata : ld_hold;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - self-checking bench for imem_dmem_arbiter
module tb_imem_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    typedef struct {
        logic        ir;
        logic [9:0]  ia;
        logic        dr;
        logic        dw;
        logic [9:0]  da;
        logic [31:0] dd;
        logic        lr;
        logic        ll;
        logic        lw;
        logic [9:0]  la;
        logic [31:0] ldd;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [2:0]  gnt;   // {ld, dm, if}
        logic        lk;
        logic [2:0]  rv;    // {ld, dm, if}
        logic [31:0] rd;
    } vec_t;

    logic        clk1;
    logic        rst_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [9:0]  if_addr;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic        ld_req, ld_lock, ld_we, ld_gnt, ld_rvalid;
    logic [9:0]  ld_addr;
    logic [31:0] ld_wdata, ld_rdata;
    logic        mem_en, mem_we, locked;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    imem_dmem_arbiter #(.AW(10), .DW(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .ld_req(ld_req), .ld_lock(ld_lock), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .locked(locked)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Synchronous single-port memory behind the arbiter
    logic [31:0] mem_arr [0:1023];
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the memory, how long fetch has waited,
    // which read is in flight and what each port last received.
    logic        m_locked;
    int          m_wait;
    int          m_pend;     // 0 none, 1 if, 2 dm, 3 ld
    logic [31:0] m_pdata;
    logic [31:0] m_hold [1:3];
    bit          m_hok  [1:3];
    logic [31:0] ref_mem [0:1023];
    int          last_win;

    function automatic stim_t st(input int ir, input int ia, input int dr, input int dw,
                                 input int da, input int dd, input int lr, input int ll,
                                 input int lw, input int la, input int ldd);
        stim_t s;
        s.ir = ir[0];  s.ia = ia[9:0];
        s.dr = dr[0];  s.dw = dw[0];  s.da = da[9:0];  s.dd = dd;
        s.lr = lr[0];  s.ll = ll[0];  s.lw = lw[0];    s.la = la[9:0];  s.ldd = ldd;
        return s;
    endfunction

    function automatic vec_t mkv(input stim_t s, input logic [2:0] g, input logic lk,
                                 input logic [2:0] rv, input logic [31:0] rd);
        vec_t v;
        v.s = s; v.gnt = g; v.lk = lk; v.rv = rv; v.rd = rd;
        return v;
    endfunction

    function automatic logic [31:0] port_rdata(input int k);
        case (k)
            1:       return if_rdata;
            2:       return dm_rdata;
            default: return ld_rdata;
        endcase
    endfunction

    function automatic logic port_rvalid(input int k);
        case (k)
            1:       return if_rvalid;
            2:       return dm_rvalid;
            default: return ld_rvalid;
        endcase
    endfunction

    task automatic set_in(input stim_t s);
        if_req = s.ir;  if_addr = s.ia;
        dm_req = s.dr;  dm_we = s.dw;  dm_addr = s.da;  dm_wdata = s.dd;
        ld_req = s.lr;  ld_lock = s.ll; ld_we = s.lw;  ld_addr = s.la;  ld_wdata = s.ldd;
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_wait   = 0;
        m_pend   = 0;
        for (int k = 1; k <= 3; k++) m_hok[k] = 1'b0;
    endtask

    task automatic model_check(input stim_t s);
        int          win;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wd;
        win = 0;
        if (s.lr) win = 3;
        else if (!m_locked) begin
            if (s.ir && m_wait == MAX_WAIT) win = 1;
            else if (s.dr)                  win = 2;
            else if (s.ir)                  win = 1;
        end
        we   = (win == 3) ? s.lw  : (win == 2) ? s.dw : 1'b0;
        addr = (win == 3) ? s.la  : (win == 2) ? s.da : (win == 1) ? s.ia : 10'd0;
        wd   = (win == 3) ? s.ldd : s.dd;

        chk("if_gnt", if_gnt, win == 1);
        chk("dm_gnt", dm_gnt, win == 2);
        chk("ld_gnt", ld_gnt, win == 3);
        chk("mem_en", mem_en, win != 0);
        chk("mem_we", mem_we, we);
        chk("mem_addr", mem_addr, addr);
        if (we) chk("mem_wdata", mem_wdata, wd);
        chk("locked", locked, m_locked);
        for (int k = 1; k <= 3; k++) begin
            chk("rvalid", port_rvalid(k), m_pend == k);
            if (m_pend == k)  chk("rdata_new", port_rdata(k), m_pdata);
            else if (m_hok[k]) chk("rdata_hold", port_rdata(k), m_hold[k]);
        end

        // Advance the model across the coming clock edge
        if (m_pend != 0) begin
            m_hold[m_pend] = m_pdata;
            m_hok[m_pend]  = 1'b1;
        end
        m_pend = 0;
        if (win != 0) begin
            if (we) ref_mem[addr] = wd;
            else begin
                m_pend  = win;
                m_pdata = ref_mem[addr];
            end
        end
        if (!s.ir || win == 1) m_wait = 0;
        else if (m_wait < MAX_WAIT) m_wait++;
        if (!m_locked) m_locked = (win == 3) && s.ll;
        else           m_locked = s.ll;
        last_win = win;
    endtask

    // One clock cycle: drive after the falling edge, check just after
    task automatic cyc(input stim_t s);
        @(negedge clk1);
        set_in(s);
        #1;
        model_check(s);
    endtask

    task automatic reset_mid(input stim_t s);
        cyc(s);
        #2 rst_n = 1'b0;
        @(posedge clk1);
        #1;
        chk("rst_if_rvalid", if_rvalid, 1'b0);
        chk("rst_ld_rvalid", ld_rvalid, 1'b0);
        chk("rst_locked", locked, 1'b0);
        set_in(st(0,0,0,0,0,0,0,0,0,0,0));
        @(negedge clk1);
        rst_n = 1'b1;
        model_reset();
        cyc(st(0,0,0,0,0,0,0,0,0,0,0));
        chk("post_rst_locked", locked, 1'b0);
        chk("post_rst_wait", dut.wait_cnt, 4'd0);
        chk("post_rst_if_rvalid", if_rvalid, 1'b0);
    endtask

    vec_t  tbl[$];
    stim_t idle_s;
    stim_t cur;
    logic [2:0] seen;

    initial begin
        idle_s = st(0,0,0,0,0,0,0,0,0,0,0);
        rst_n  = 1'b0;
        set_in(idle_s);
        model_reset();
        repeat (2) @(posedge clk1);
        #1;
        chk("reset_locked", locked, 1'b0);
        chk("reset_rvalid", {ld_rvalid, dm_rvalid, if_rvalid}, 3'b000);
        chk("reset_mem_en", mem_en, 1'b0);
        @(negedge clk1);
        rst_n = 1'b1;

        // Loader burst, fetch, contention with lock and starvation
        tbl.push_back(mkv(st(1,0, 0,0,0,0, 1,1,1,0,32'h2801000A), 3'b100, 1'b0, 3'b000, 32'h0));
        tbl.push_back(mkv(st(1,0, 0,0,0,0, 1,1,1,1,32'h28020005), 3'b100, 1'b1, 3'b000, 32'h0));
        tbl.push_back(mkv(st(1,0, 0,0,0,0, 1,0,1,2,32'h00221800), 3'b100, 1'b1, 3'b000, 32'h0));
        tbl.push_back(mkv(st(1,0, 0,0,0,0, 0,0,0,0,0),            3'b001, 1'b0, 3'b000, 32'h0));
        tbl.push_back(mkv(st(1,1, 0,0,0,0, 0,0,0,0,0),            3'b001, 1'b0, 3'b001, 32'h2801000A));
        tbl.push_back(mkv(st(1,2, 1,0,1,0, 0,0,0,0,0),            3'b010, 1'b0, 3'b001, 32'h28020005));
        tbl.push_back(mkv(st(1,2, 0,0,0,0, 0,0,0,0,0),            3'b001, 1'b0, 3'b010, 32'h28020005));
        tbl.push_back(mkv(st(0,0, 0,0,0,0, 0,0,0,0,0),            3'b000, 1'b0, 3'b001, 32'h00221800));
        tbl.push_back(mkv(st(1,0, 0,0,0,0, 1,1,0,0,0),            3'b100, 1'b0, 3'b000, 32'h0));
        tbl.push_back(mkv(st(1,0, 1,0,2,0, 0,1,0,0,0),            3'b000, 1'b1, 3'b100, 32'h2801000A));
        tbl.push_back(mkv(st(1,0, 1,0,2,0, 0,0,0,0,0),            3'b000, 1'b1, 3'b000, 32'h0));
        tbl.push_back(mkv(st(1,0, 1,0,2,0, 0,0,0,0,0),            3'b010, 1'b0, 3'b000, 32'h0));
        tbl.push_back(mkv(st(1,0, 1,0,2,0, 0,0,0,0,0),            3'b001, 1'b0, 3'b010, 32'h00221800));
        tbl.push_back(mkv(st(0,0, 0,0,0,0, 0,0,0,0,0),            3'b000, 1'b0, 3'b001, 32'h2801000A));

        foreach (tbl[i]) begin
            cyc(tbl[i].s);
            chk($sformatf("tbl%0d_gnt", i), {ld_gnt, dm_gnt, if_gnt}, tbl[i].gnt);
            chk($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
            chk($sformatf("tbl%0d_rvalid", i), {ld_rvalid, dm_rvalid, if_rvalid}, tbl[i].rv);
            if (tbl[i].rv[0]) chk($sformatf("tbl%0d_rdata", i), if_rdata, tbl[i].rd);
            if (tbl[i].rv[1]) chk($sformatf("tbl%0d_rdata", i), dm_rdata, tbl[i].rd);
            if (tbl[i].rv[2]) chk($sformatf("tbl%0d_rdata", i), ld_rdata, tbl[i].rd);
        end

        // Store then load the same word on consecutive cycles
        cyc(st(0,0, 1,1,20,15, 0,0,0,0,0));
        chk("sw_gnt", dm_gnt, 1'b1);
        cyc(st(0,0, 1,0,20,0, 0,0,0,0,0));
        chk("lw_gnt", dm_gnt, 1'b1);
        cyc(idle_s);
        chk("lw_rvalid", dm_rvalid, 1'b1);
        chk("lw_rdata", dm_rdata, 32'd15);

        // Fetch and load in the same cycle: data first, fetch next
        cyc(st(1,0, 1,0,20,0, 0,0,0,0,0));
        chk("cont_gnt", {dm_gnt, if_gnt}, 2'b10);
        cyc(st(1,0, 0,0,0,0, 0,0,0,0,0));
        chk("cont_if_gnt", if_gnt, 1'b1);
        chk("cont_dm_rvalid", dm_rvalid, 1'b1);
        chk("cont_dm_rdata", dm_rdata, 32'd15);
        cyc(idle_s);
        chk("cont_if_rvalid", {dm_rvalid, if_rvalid}, 2'b01);
        chk("cont_if_rdata", if_rdata, 32'h2801000A);

        // Fetch starved by a continuous data stream
        for (int i = 0; i < 6; i++) begin
            cyc(st(1,1, 1,0,2,0, 0,0,0,0,0));
            chk($sformatf("starve%0d_gnt", i), {dm_gnt, if_gnt}, (i == 4) ? 2'b01 : 2'b10);
            if (i == 5) chk("starve_wait_cleared", dut.wait_cnt, 4'd0);
        end
        cyc(idle_s);
        cyc(idle_s);

        // Reset while a fetch read and a locked loader read are in flight
        reset_mid(st(1,0, 0,0,0,0, 0,0,0,0,0));
        reset_mid(st(1,0, 0,0,0,0, 1,1,0,1,0));

        // Fill a small window of memory with a locked loader burst
        for (int a = 0; a < 32; a++)
            cyc(st(0,0, 0,0,0,0, 1,(a != 31),1,a,$urandom));
        cyc(idle_s);
        chk("fill_unlocked", locked, 1'b0);

        // Randomised traffic that honours hold-until-grant
        cur = idle_s;
        for (int n = 0; n < 600; n++) begin
            cyc(cur);
            seen = {last_win == 3, last_win == 2, last_win == 1};
            if (!cur.ir || seen[0] || $urandom_range(0, 15) == 0) begin
                cur.ir = 1'($urandom_range(0, 1));
                cur.ia = 10'($urandom_range(0, 31));
            end
            if (!cur.dr || seen[1] || $urandom_range(0, 15) == 0) begin
                cur.dr = 1'($urandom_range(0, 1));
                cur.dw = 1'($urandom_range(0, 1));
                cur.da = 10'($urandom_range(0, 31));
                cur.dd = $urandom;
            end
            if (!cur.lr || seen[2]) begin
                cur.lr  = ($urandom_range(0, 3) == 0);
                cur.lw  = 1'($urandom_range(0, 1));
                cur.la  = 10'($urandom_range(0, 31));
                cur.ldd = $urandom;
            end
            cur.ll = ($urandom_range(0, 3) == 0);
        end
        cyc(idle_s);
        cyc(idle_s);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
Arbitrates the processor's single-ported 1024x32 unified MEMORY between three requesters:
- instruction fetch (IF stage)
- data access (MEM stage, LW/SW)
- program loader/debug port, which preloads code such as ADDI/ADD/BEQZ words
Gives fixed priority with fetch anti-starvation, a loader lock for burst programming, and routes 1-cycle-latency read data back to the issuing requester.

Parameters:
AW, 10, memory word-address width (1024 words)
DW, 32, data/instruction width
MAX_WAIT, 4, consecutive denied fetch cycles after which fetch outranks data port (1..15)

Ports:
clk1  in  1  single processor clock, rising-edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch read request
if_addr  in  AW  fetch address
if_gnt  out  1  fetch access issued this cycle
if_rvalid  out  1  fetch read data valid
if_rdata  out  DW  fetch read data
dm_req  in  1  data request
dm_we  in  1  1=store (SW), 0=load (LW)
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_gnt  out  1  data access issued this cycle
dm_rvalid  out  1  load data valid
dm_rdata  out  DW  load data
ld_req  in  1  loader request
ld_lock  in  1  loader keeps ownership after this access
ld_we  in  1  loader write enable
ld_addr  in  AW  loader address
ld_wdata  in  DW  loader write data
ld_gnt  out  1  loader access issued this cycle
ld_rvalid  out  1  loader read data valid
ld_rdata  out  DW  loader read data
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  synchronous read data, valid cycle after mem_en&!mem_we
locked  out  1  state==LOCKED

Behaviour:
- Reset (async, rst_n=0): state=ARB, wait_cnt=0, owner tag=NONE, all *_rvalid=0, locked=0. gnt/mem_* are combinational and low while no request.
- Grants are combinational in the request cycle; at most one gnt per cycle. mem_en=|gnt; mem_we/addr/wdata muxed from winner (if_* always read).
- State ARB priority: ld > (fetch if wait_cnt==MAX_WAIT) > dm > if.
- State LOCKED: only ld may be granted; if/dm gnt forced 0; wait_cnt still counts.
- Transitions:
  - ARB->LOCKED on ld_gnt & ld_lock.
  - LOCKED->ARB on any cycle with ld_lock=0; a concurrent ld_req is still granted that cycle.
  - LOCKED with ld_lock=1 and no ld_req: stay, memory idle.
- wait_cnt (4-bit):
  - reset to 0 when if_gnt or !if_req.
  - else +1, saturating at MAX_WAIT.
- Read return:
  - Registered owner tag captures the winner of a read.
  - Next cycle, that requester's rvalid=1 and its rdata=mem_rdata; other rdata hold last value.
  - Writes produce no rvalid.
  - Back-to-back reads are fully pipelined, one per cycle.
- Requester must hold req/addr/wdata stable until its gnt; dropping req before gnt is legal (no access).
- Read-after-write to same address on consecutive cycles returns new data (memory write-first; arbiter adds no bypass).
- Reset mid-read: pending rvalid is suppressed, tag cleared.

Decomposition:
- Shared package mem_arb_pkg: owner enum {OWN_NONE, OWN_IF, OWN_DM, OWN_LD}, state enum {ARB, LOCKED}, AW/DW defaults.
- Opcode constants (ADD..HLT, 6-bit) stay in the existing processor package; the bench uses them.
- One natural sub-module: arb_prio_sel (combinational priority/starvation select, outputs winner one-hot).

Test Plan:
- Fetch only: if_req=1, if_addr=0, MEMORY[0]=0x2801000A -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=0x2801000A.
- Contention: if_req & dm_req (LW addr 20) same cycle -> dm_gnt=1, if_gnt=0; following cycle (dm_req=0) if_gnt=1; dm_rvalid precedes if_rvalid by one cycle.
- Starvation: dm_req held 6 cycles, if_req held, MAX_WAIT=4 -> dm wins cycles 0-3, if_gnt in cycle 4, dm resumes cycle 5; wait_cnt back to 0.
- Loader burst: ld_lock=1, writes 0x2801000A, 0x28020005, 0x00221800 to addr 0-2 over 3 cycles while if_req=1 -> locked=1, if_gnt=0 throughout; ld_lock=0 on third write -> state ARB, if_gnt next cycle.
- Store then load: dm SW addr 20 data 15, next cycle LW addr 20 -> dm_rvalid=1, dm_rdata=15.
- Reset mid-read: fetch granted, rst_n low before next edge -> if_rvalid stays 0, locked=0, wait_cnt=0 after release.
